// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed Booth multiplier and restoring divider feeding the MIPS Hi/Lo registers.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] mult_hi,
  output logic [31:0] mult_lo,
  output logic [31:0] div_hi,
  output logic [31:0] div_lo
);
  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [65:0] p_q, p_d, p_step;
  logic [32:0] b_q, b_d, booth_acc, r_sh, diff;
  logic [31:0] r_q, r_d, q_q, q_d, r_step, q_step, a_mag, b_mag;
  logic        q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic        busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic [31:0] mh_q, mh_d, ml_q, ml_d, dh_q, dh_d, dl_q, dl_d;
  always_comb begin
    a_mag = a_in[31] ? -a_in : a_in;
    b_mag = b_in[31] ? -b_in : b_in;
    // acc is one bit wider than the operand so negating 0x80000000 cannot overflow
    booth_acc = (p_q[1:0] == 2'b01) ? p_q[65:33] + b_q :
                (p_q[1:0] == 2'b10) ? p_q[65:33] - b_q : p_q[65:33];
    p_step = 66'($signed({booth_acc, p_q[32:0]}) >>> 1);
    r_sh = {r_q, q_q[31]};
    diff = r_sh - b_q;
    r_step = diff[32] ? r_sh[31:0] : diff[31:0];
    q_step = {q_q[30:0], ~diff[32]};
    state_d = state_q;
    cnt_d = cnt_q;
    p_d = p_q;
    b_d = b_q;
    r_d = r_q;
    q_d = q_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    busy_d = 1'b0;
    done_d = 1'b0;
    dz_d = 1'b0;
    mh_d = mh_q;
    ml_d = ml_q;
    dh_d = dh_q;
    dl_d = dl_q;
    case (state_q)
      IDLE: if (start) begin
        cnt_d = 5'd0;
        if (!op) begin
          p_d = {33'd0, a_in, 1'b0};
          b_d = {b_in[31], b_in};
          state_d = MULT;
          busy_d = 1'b1;
        end else if (b_in == 32'd0) begin
          state_d = DONE;
          done_d = 1'b1;
          dz_d = 1'b1;
        end else begin
          r_d = 32'd0;
          q_d = a_mag;
          b_d = {1'b0, b_mag};
          q_neg_d = a_in[31] ^ b_in[31];
          r_neg_d = a_in[31];
          state_d = DIV;
          busy_d = 1'b1;
        end
      end
      MULT: begin
        p_d = p_step;
        cnt_d = cnt_q + 5'd1;
        busy_d = cnt_q != 5'd31;
        if (cnt_q == 5'd31) begin
          mh_d = p_step[64:33];
          ml_d = p_step[32:1];
          state_d = DONE;
          done_d = 1'b1;
        end
      end
      DIV: begin
        r_d = r_step;
        q_d = q_step;
        cnt_d = cnt_q + 5'd1;
        busy_d = cnt_q != 5'd31;
        if (cnt_q == 5'd31) begin
          dl_d = q_neg_q ? -q_step : q_step;
          dh_d = r_neg_q ? -r_step : r_step;
          state_d = DONE;
          done_d = 1'b1;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= 5'd0;
      p_q <= 66'd0;
      b_q <= 33'd0;
      r_q <= 32'd0;
      q_q <= 32'd0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q <= 1'b0;
      mh_q <= 32'd0;
      ml_q <= 32'd0;
      dh_q <= 32'd0;
      dl_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      p_q <= p_d;
      b_q <= b_d;
      r_q <= r_d;
      q_q <= q_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      busy_q <= busy_d;
      done_q <= done_d;
      dz_q <= dz_d;
      mh_q <= mh_d;
      ml_q <= ml_d;
      dh_q <= dh_d;
      dl_q <= dl_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign div_zero = dz_q;
  assign mult_hi = mh_q;
  assign mult_lo = ml_q;
  assign div_hi = dh_q;
  assign div_lo = dl_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        busy, done, div_zero;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .div_zero(div_zero),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .div_hi(div_hi), .div_lo(div_lo)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] mh, ml, dh, dl;
    bit dz;
    int s, c;
  } exp_t;
  exp_t sb[$];
  exp_t me;
  bit has;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  logic [31:0] m_hi = '0, m_lo = '0, d_hi = '0, d_lo = '0;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) if (!reset) begin
    has = sb.size() > 0;
    if (has) me = sb[0];
    chk("busy_done_excl", 32'(busy & done), 32'd0);
    if (done) begin
      if (!has) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        me = sb.pop_front();
        chk("done_cycle", cyc, me.c);
        chk("div_zero", 32'(div_zero), 32'(me.dz));
        chk("mult_hi", mult_hi, me.mh);
        chk("mult_lo", mult_lo, me.ml);
        chk("div_hi", div_hi, me.dh);
        chk("div_lo", div_lo, me.dl);
      end
    end else begin
      chk("busy", 32'(busy), 32'(has && !me.dz && cyc > me.s && cyc < me.c));
      chk("div_zero_idle", 32'(div_zero), 32'd0);
    end
  end
  task automatic push(input bit o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint pr, sa, sb_, qv, rv;
    e.dz = 1'b0;
    if (!o) begin
      pr = longint'($signed(a)) * longint'($signed(b));
      m_hi = pr[63:32];
      m_lo = pr[31:0];
    end else if (b == 32'd0) e.dz = 1'b1;
    else begin
      sa = longint'($signed(a));
      sb_ = longint'($signed(b));
      qv = sa / sb_;
      rv = sa % sb_;
      d_lo = qv[31:0];
      d_hi = rv[31:0];
    end
    e.mh = m_hi; e.ml = m_lo; e.dh = d_hi; e.dl = d_lo;
    e.s = cyc;
    e.c = cyc + (e.dz ? 1 : 33);
    sb.push_back(e);
  endtask
  task automatic issue(input bit o, input logic [31:0] a, input logic [31:0] b, input int glitch);
    push(o, a, b);
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 40 && !done; i++) begin
      if (i == glitch) begin
        start = 1'b1; op = ~o; a_in = $urandom; b_in = $urandom;
      end
      @(negedge clk);
      start = 1'b0;
    end
    chk("done_seen", 32'(done), 32'd1);
    @(negedge clk);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_dz"}, 32'(div_zero), 32'd0);
    chk({tag, "_mhi"}, mult_hi, 32'd0);
    chk({tag, "_mlo"}, mult_lo, 32'd0);
    chk({tag, "_dhi"}, div_hi, 32'd0);
    chk({tag, "_dlo"}, div_lo, 32'd0);
  endtask
  function automatic logic [31:0] pick(input bit allow_zero);
    case ($urandom_range(7, 0))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return allow_zero ? 32'd0 : 32'd1;
      3: return 32'($urandom_range(20, 0)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_zero("reset");
    issue(1'b0, 32'd7, 32'hFFFF_FFFD, 0);
    chk("plan_mhi", mult_hi, 32'hFFFF_FFFF);
    chk("plan_mlo", mult_lo, 32'hFFFF_FFEB);
    issue(1'b0, 32'h8000_0000, 32'h8000_0000, 0);
    chk("plan_ext_mhi", mult_hi, 32'h4000_0000);
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("plan_ones_mlo", mult_lo, 32'd1);
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    chk("plan_div_lo", div_lo, 32'hFFFF_FFFD);
    chk("plan_div_hi", div_hi, 32'hFFFF_FFFF);
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    chk("plan_div2_hi", div_hi, 32'd1);
    issue(1'b1, 32'd5, 32'd0, 0);
    chk("plan_dz_hold", div_lo, 32'hFFFF_FFFD);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("plan_ovf_lo", div_lo, 32'h8000_0000);
    issue(1'b0, 32'd3, 32'd4, 5);
    chk("plan_ignored", mult_lo, 32'd12);
    push(1'b0, 32'd9, 32'd9);
    start = 1'b1; op = 1'b0; a_in = 32'd9; b_in = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    m_hi = '0; m_lo = '0; d_hi = '0; d_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    check_zero("abort");
    repeat (40) @(negedge clk);
    issue(1'b0, 32'd6, 32'hFFFF_FFF9, 0);
    for (int n = 0; n < 60; n++) begin
      issue(1'($urandom_range(1, 0)), pick(1'b0), pick(1'b1), ($urandom_range(3, 0) == 0) ? int'($urandom_range(30, 1)) : 0);
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
